// File: rtl/riscv_pkg.sv
// riscv_pkg: constants shared by the fetch stage and cntrl_block.
//   - Major opcode values for the instruction classes decode understands.
//   - NOP_INSTR: canonical NOP (addi x0,x0,0) presented when nothing is fetched.
//   - PC_INC: byte distance between consecutive instruction words.
package riscv_pkg;

  localparam logic [6:0] OPCODE_R = 7'b0110011;
  localparam logic [6:0] OPCODE_I = 7'b0010011;
  localparam logic [6:0] OPCODE_B = 7'b1100011;
  localparam logic [6:0] OPCODE_S = 7'b0100011;
  localparam logic [6:0] OPCODE_L = 7'b0000011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO buffering fetched {pc, instr} entries.
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset (pointers/count only)
//   push       in   write push_data at the tail
//   push_data  in   WIDTH-bit entry
//   pop        in   drop the head entry (ignored when empty)
//   flush      in   discard all entries; overrides push and pop
//   head_data  out  current head entry (valid when !empty)
//   count      out  number of stored entries
//   empty      out  count == 0
//   full       out  count == DEPTH
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign count     = count_reg;
  // A push into a full buffer only makes room if the head leaves in the same cycle.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  // The head is read straight from the entry register so decode sees it the
  // cycle after it was written.
  assign head_data = mem_reg[rd_ptr_reg];

  // Entry storage carries no reset; only pointers and count define validity.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && !flush && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (push && !flush) |-> (!full || pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding cntrl_block.
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-low reset
//   imem_req_valid   out  read request valid
//   imem_req_ready   in   memory accepts the request
//   imem_addr        out  word-aligned fetch address
//   imem_rsp_valid   in   in-order read data valid, one per accepted request
//   imem_rdata       in   instruction word
//   fetch_valid      out  instr_reg_fetch/pc_fetch valid to decode
//   decode_ready     in   decode consumes the head entry
//   instr_reg_fetch  out  instruction (NOP when nothing buffered)
//   pc_fetch         out  PC of instr_reg_fetch (0 when nothing buffered)
//   redirect_valid   in   flush and restart fetching at redirect_pc
//   redirect_pc      in   new PC, low two bits ignored
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  fetch_valid,
  input  logic                  decode_ready,
  output logic [DATA_WIDTH-1:0] instr_reg_fetch,
  output logic [DATA_WIDTH-1:0] pc_fetch,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(PC_INC);

  logic [DATA_WIDTH-1:0]   pc_req_reg, rsp_pc_reg;
  logic [CW-1:0]           outstanding_reg, discard_reg;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty, fifo_full;
  logic [2*DATA_WIDTH-1:0] fifo_head;
  logic [CW:0]             credit_used;
  logic                    req_fire, push, pop;
  logic [DATA_WIDTH-1:0]   redirect_pc_aligned;
  logic                    unused_redirect_lsb;

  assign redirect_pc_aligned = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Every request in flight already owns a buffer slot, so a response can
  // always be accepted without stalling the memory.
  assign credit_used    = {1'b0, outstanding_reg} + {1'b0, fifo_count};
  assign imem_req_valid = rst && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr      = pc_req_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses belonging to requests issued before a redirect are dropped,
  // including one that lands in the redirect cycle itself.
  assign push = imem_rsp_valid && !redirect_valid && (discard_reg == '0);

  assign fetch_valid     = !fifo_empty;
  assign pop             = fetch_valid && decode_ready && !redirect_valid;
  assign instr_reg_fetch = fifo_empty ? DATA_WIDTH'(NOP_INSTR) : fifo_head[DATA_WIDTH-1:0];
  assign pc_fetch        = fifo_empty ? '0 : fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_req_reg      <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        pc_req_reg  <= redirect_pc_aligned;
        rsp_pc_reg  <= redirect_pc_aligned;
        // Everything still in flight is stale, minus the response dropped now.
        discard_reg <= outstanding_reg - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc_req_reg <= pc_req_reg + PC_STEP;
        if (push)     rsp_pc_reg <= rsp_pc_reg + PC_STEP;
        if (imem_rsp_valid && (discard_reg != '0)) discard_reg <= discard_reg - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*DATA_WIDTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({rsp_pc_reg, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (outstanding_reg != '0));
  a_discard_bounded: assert property (@(posedge clk) disable iff (!rst)
    discard_reg <= outstanding_reg);
  a_push_has_room: assert property (@(posedge clk) disable iff (!rst)
    push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int FIFO_DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic        decode_ready;
  logic [31:0] instr_reg_fetch;
  logic [31:0] pc_fetch;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  instr_fetch_unit #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rdata      (imem_rdata),
    .fetch_valid     (fetch_valid),
    .decode_ready    (decode_ready),
    .instr_reg_fetch (instr_reg_fetch),
    .pc_fetch        (pc_fetch),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory request in flight: address the DUT sent, PC the model expected,
  // cycle the response is due, and redirect epoch it was issued in.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] mpc;
    int          due;
    int          ep;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] mq_pc[$];      // model fetch buffer: PCs decode should see, in order
  logic [31:0] obs_pc[$];
  logic [31:0] obs_instr[$];
  logic [31:0] m_req_pc;
  int          m_epoch;
  int          cyc;
  int          acc_count;
  int          fixed_lat;
  bit          rand_lat;
  int          n_pass;
  int          n_total;

  function automatic logic [6:0] op_of(input int k);
    case (k)
      0:       return 7'b0110011;
      1:       return 7'b0010011;
      2:       return 7'b1100011;
      3:       return 7'b0100011;
      default: return 7'b0000011;
    endcase
  endfunction

  // Memory contents: opcode cycles R,I,B,S,L with the word index, upper bits from the PC.
  function automatic logic [31:0] word_at(input logic [31:0] pc);
    int k;
    k = int'((pc >> 2) % 5);
    return {pc[26:2], op_of(k)};
  endfunction

  task automatic tick();
    logic exp_req, rsp, m_pop, m_acc, dut_acc;
    logic [31:0] dut_addr;
    int lat;
    mreq_t e;
    rsp = (memq.size() != 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rdata = rsp ? word_at(memq[0].addr) : 32'h0;
    #1;
    exp_req = !redirect_valid && ((memq.size() + mq_pc.size()) < FIFO_DEPTH);
    n_total++;
    if (imem_req_valid !== exp_req)
      $display("FAIL req_valid cyc=%0d got=%0b exp=%0b", cyc, imem_req_valid, exp_req);
    else n_pass++;
    if (exp_req) begin
      n_total++;
      if (imem_addr !== m_req_pc)
        $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_req_pc);
      else n_pass++;
    end
    n_total++;
    if (fetch_valid !== (mq_pc.size() != 0))
      $display("FAIL fetch_valid cyc=%0d got=%0b exp=%0b", cyc, fetch_valid, mq_pc.size() != 0);
    else n_pass++;
    if (mq_pc.size() != 0) begin
      n_total++;
      if (pc_fetch !== mq_pc[0] || instr_reg_fetch !== word_at(mq_pc[0]))
        $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                 cyc, pc_fetch, instr_reg_fetch, mq_pc[0], word_at(mq_pc[0]));
      else n_pass++;
    end else begin
      n_total++;
      if (pc_fetch !== 32'h0 || instr_reg_fetch !== NOP)
        $display("FAIL idle_out cyc=%0d got pc=%h instr=%h exp pc=0 instr=%h",
                 cyc, pc_fetch, instr_reg_fetch, NOP);
      else n_pass++;
    end
    m_pop    = (mq_pc.size() != 0) && decode_ready && !redirect_valid;
    m_acc    = exp_req && imem_req_ready;
    dut_acc  = imem_req_valid && imem_req_ready;
    dut_addr = imem_addr;
    if (fetch_valid && decode_ready && !redirect_valid) begin
      obs_pc.push_back(pc_fetch);
      obs_instr.push_back(instr_reg_fetch);
      $display("cyc %0d decode pc=%h instr=%h", cyc, pc_fetch, instr_reg_fetch);
    end
    @(posedge clk);
    if (rsp) e = memq.pop_front();
    if (redirect_valid) begin
      m_epoch++;
      m_req_pc = {redirect_pc[31:2], 2'b00};
      mq_pc.delete();
    end else begin
      if (m_pop) void'(mq_pc.pop_front());
      if (rsp && e.ep == m_epoch) mq_pc.push_back(e.mpc);
    end
    lat = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
    if (dut_acc) begin
      memq.push_back('{addr: dut_addr, mpc: m_req_pc, due: cyc + lat, ep: m_epoch});
      acc_count++;
    end
    if (m_acc) m_req_pc = m_req_pc + 32'd4;
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_model();
    memq.delete();
    mq_pc.delete();
    obs_pc.delete();
    obs_instr.delete();
    m_req_pc  = 32'h0;
    m_epoch++;
    acc_count = 0;
  endtask

  task automatic apply_reset();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    decode_ready   = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata     = 32'h0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_model();
    rst = 1'b1;
  endtask

  task automatic run_until_obs(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (obs_pc.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (obs_pc.size() < n) begin
      n_total++;
      $display("FAIL %s_timeout got=%0d words exp=%0d", name, obs_pc.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; decode_ready = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0)
      $display("FAIL reset_valids got req=%0b fv=%0b exp 0 0", imem_req_valid, fetch_valid);
    else n_pass++;
    n_total++;
    if (instr_reg_fetch !== NOP || pc_fetch !== 32'h0)
      $display("FAIL reset_outputs got instr=%h pc=%h exp %h 0", instr_reg_fetch, pc_fetch, NOP);
    else n_pass++;
    @(negedge clk);
    clear_model();
    rst = 1'b1;
    #1;
    n_total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL reset_first_req got v=%0b addr=%h exp 1 0", imem_req_valid, imem_addr);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_streaming();
    apply_reset();
    rand_lat = 0; fixed_lat = 1;
    imem_req_ready = 1'b1; decode_ready = 1'b1;
    run_until_obs(5, 60, "stream");
    for (int i = 0; i < 5 && i < obs_pc.size(); i++) begin
      n_total++;
      if (obs_pc[i] !== 32'(i * 4) || obs_instr[i][6:0] !== op_of(i))
        $display("FAIL stream_word%0d got pc=%h op=%b exp pc=%h op=%b",
                 i, obs_pc[i], obs_instr[i][6:0], 32'(i * 4), op_of(i));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rand_lat = 0; fixed_lat = 1;
    imem_req_ready = 1'b1; decode_ready = 1'b0;
    repeat (10) tick();
    #1;
    n_total++;
    if (acc_count != FIFO_DEPTH || imem_req_valid !== 1'b0)
      $display("FAIL bp_credit got reqs=%0d req_valid=%0b exp %0d 0", acc_count, imem_req_valid, FIFO_DEPTH);
    else n_pass++;
    n_total++;
    if (fetch_valid !== 1'b1 || pc_fetch !== 32'h0)
      $display("FAIL bp_head got fv=%0b pc=%h exp 1 0", fetch_valid, pc_fetch);
    else n_pass++;
    decode_ready = 1'b1;
    run_until_obs(FIFO_DEPTH + 3, 60, "bp");
    for (int i = 0; i < FIFO_DEPTH + 3 && i < obs_pc.size(); i++) begin
      n_total++;
      if (obs_pc[i] !== 32'(i * 4))
        $display("FAIL bp_word%0d got pc=%h exp %h", i, obs_pc[i], 32'(i * 4));
      else n_pass++;
    end
  endtask

  task automatic test_redirect_inflight();
    int k;
    apply_reset();
    rand_lat = 0; fixed_lat = 3;
    imem_req_ready = 1'b1; decode_ready = 1'b1;
    k = 0;
    while (memq.size() < 2 && k < 30) begin tick(); k++; end
    n_total++;
    if (memq.size() < 2) $display("FAIL redir_setup got inflight=%0d exp 2", memq.size());
    else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    obs_pc.delete(); obs_instr.delete();
    run_until_obs(2, 40, "redir");
    if (obs_pc.size() >= 2) begin
      n_total++;
      if (obs_pc[0] !== 32'h100 || obs_instr[0] !== word_at(32'h100) || obs_pc[1] !== 32'h104)
        $display("FAIL redir_target got pc=%h,%h exp 100,104", obs_pc[0], obs_pc[1]);
      else n_pass++;
    end
  endtask

  task automatic test_redirect_same_cycle();
    int k;
    logic [31:0] tgt;
    apply_reset();
    rand_lat = 0; fixed_lat = 2;
    imem_req_ready = 1'b1; decode_ready = 1'b1;
    repeat (3) tick();
    k = 0;
    while (!((memq.size() != 0) && (memq[0].due <= cyc) && (mq_pc.size() != 0)) && k < 40) begin
      tick(); k++;
    end
    n_total++;
    if (k >= 40) $display("FAIL same_setup got no rsp+pop cycle exp one within 40");
    else n_pass++;
    tgt = {$urandom_range(16'h0100, 16'h7fff), 16'h0} & 32'hFFFF_FFFC;
    redirect_valid = 1'b1; redirect_pc = tgt;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_total++;
    if (fetch_valid !== 1'b0)
      $display("FAIL same_flush got fv=%0b exp 0", fetch_valid);
    else n_pass++;
    obs_pc.delete(); obs_instr.delete();
    run_until_obs(1, 40, "same");
    if (obs_pc.size() >= 1) begin
      n_total++;
      if (obs_pc[0] !== tgt) $display("FAIL same_target got pc=%h exp %h", obs_pc[0], tgt);
      else n_pass++;
    end
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    rand_lat = 0; fixed_lat = 1;
    imem_req_ready = 1'b1; decode_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    obs_pc.delete(); obs_instr.delete();
    run_until_obs(2, 30, "wrap");
    if (obs_pc.size() >= 2) begin
      n_total++;
      if (obs_pc[0] !== 32'hFFFF_FFFC || obs_pc[1] !== 32'h0)
        $display("FAIL wrap_seq got pc=%h,%h exp fffffffc,00000000", obs_pc[0], obs_pc[1]);
      else n_pass++;
    end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    obs_pc.delete(); obs_instr.delete();
    run_until_obs(1, 30, "unaligned");
    if (obs_pc.size() >= 1) begin
      n_total++;
      if (obs_pc[0] !== 32'h100) $display("FAIL unaligned_target got pc=%h exp 100", obs_pc[0]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rand_lat = 0; fixed_lat = 3;
    imem_req_ready = 1'b1; decode_ready = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    obs_pc.delete(); obs_instr.delete();
    run_until_obs(1, 40, "b2b");
    if (obs_pc.size() >= 1) begin
      n_total++;
      if (obs_pc[0] !== 32'h300) $display("FAIL b2b_target got pc=%h exp 300", obs_pc[0]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    apply_reset();
    rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      decode_ready   = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    rand_lat = 0; fixed_lat = 1;
    imem_req_ready = 1'b1; decode_ready = 1'b1;
    repeat (15) tick();
    #2 rst = 1'b0;
    #1;
    n_total++;
    if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0 ||
        instr_reg_fetch !== NOP || pc_fetch !== 32'h0)
      $display("FAIL async_reset got req=%0b fv=%0b instr=%h pc=%h exp 0 0 %h 0",
               imem_req_valid, fetch_valid, instr_reg_fetch, pc_fetch, NOP);
    else n_pass++;
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    clear_model();
    rst = 1'b1;
    #1;
    n_total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL post_reset_req got v=%0b addr=%h exp 1 0", imem_req_valid, imem_addr);
    else n_pass++;
    run_until_obs(2, 30, "post_reset");
    if (obs_pc.size() >= 2) begin
      n_total++;
      if (obs_pc[0] !== 32'h0 || obs_pc[1] !== 32'h4)
        $display("FAIL post_reset_seq got pc=%h,%h exp 0,4", obs_pc[0], obs_pc[1]);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; m_epoch = 0; acc_count = 0;
    fixed_lat = 1; rand_lat = 0; m_req_pc = 32'h0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_pc_wrap();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
